candy_mem_resp: RTL and testbench
=================================

Name: candy_mem_resp

Overview:
Memory responder for the candy core's SRAM read/write interface. It serves the instruction-fetch read handshake (read_enable / raddr -> rdata / rdata_ready) and the write-back write port (write_enable / waddr / wdata). Storage is an internal word-addressed array. It sits between candy_if / candy_wb and the storage, with configurable read latency and a busy indication.

Parameters:
ADDR_W, 16, address width; matches the SRAMAddrWidth define.
DATA_W, 32, data width; matches the SRAMDataWidth define.
DEPTH, 1024, number of words; addresses >= DEPTH are out of range.
RD_LAT, 2, cycles from read acceptance to rdata_ready; legal range 1..15.

Ports:
clk  in  1  clock; all logic on the rising edge.
rst  in  1  synchronous, active-high reset.
read_enable  in  1  read request level; held by the requester until rdata_ready.
raddr  in  ADDR_W  read address; sampled at acceptance.
rdata  out  DATA_W  read data; valid while rdata_ready=1; held until the next response.
rdata_ready  out  1  one-cycle pulse marking a valid rdata.
write_enable  in  1  one-cycle write strobe; always accepted, no backpressure.
waddr  in  ADDR_W  write address.
wdata  in  DATA_W  write data.
busy  out  1  high while a read is in flight (BUSY or RESP state).

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, rdata=0, rdata_ready=0, busy=0, latency counter=0. Array contents are not cleared.
- Reset during an in-flight read aborts it. No rdata_ready is issued for the aborted read.
- FSM states: IDLE, BUSY, RESP.
- IDLE, read_enable=1 at edge N:
  - Accept the read and latch raddr.
  - Read the array at that edge into a holding register.
  - If RD_LAT=1, go to RESP. Otherwise go to BUSY with cnt=RD_LAT-1.
- BUSY: decrement cnt each edge. Go to RESP when cnt reaches 1 at an edge.
- RESP: rdata_ready=1 and rdata=held word, driven from registers. Next edge: return to IDLE unconditionally; read_enable is ignored in RESP.
- Latency: rdata_ready is high in cycle N+RD_LAT, where edge N is the acceptance edge. Minimum spacing between read acceptances is RD_LAT+1 cycles.
- A requester that keeps read_enable high in the IDLE cycle after RESP issues a new read.
- read_enable falling before rdata_ready: the read still completes and rdata_ready still pulses. The requester must not drop read_enable early.
- Writes: write_enable=1 at an edge commits wdata to mem[waddr] at that edge, in any FSM state.
- Simultaneous read acceptance and write to the same address at the same edge: write-first. The held word equals wdata.
- A write to the held address after acceptance does not change the pending rdata; the snapshot is taken at acceptance.
- Out-of-range read (raddr >= DEPTH): completes with normal timing, rdata=0.
- Out-of-range write: ignored; the array is unchanged.
- Address comparison is full-width and unsigned. No wrap-around modulo DEPTH.
- rdata_ready is never high in two consecutive cycles.
- busy=1 exactly in BUSY and RESP.

Optional Feature:
Macro: CANDY_MEM_RESP_ERR_EN.
- Defined: adds output port addr_err (1 bit, reset 0).
  - Pulses in the RESP cycle of an out-of-range read.
  - Pulses in the cycle after an edge that ignored an out-of-range write.
  - Both cases in the same cycle: a single pulse.
- Undefined: the port is absent. Out-of-range handling is otherwise identical.

Decomposition:
- Shared defines in candy_defines.v: the SRAMAddrWidth/SRAMDataWidth macros, the FSM state encodings (2-bit: IDLE=0, BUSY=1, RESP=2), and the default RD_LAT.
- One sub-module: candy_mem_array.
  - Contains the DEPTH x DATA_W storage.
  - One synchronous write port and one synchronous read port with write-first bypass.
  - Performs the range check internally.
- The FSM and counter stay in candy_mem_resp.

Test Plan:
- Reset then write: rst 2 cycles; write mem[5]=0xDEADBEEF; read 5 with RD_LAT=2. Expect rdata_ready exactly 2 cycles after acceptance, rdata=0xDEADBEEF, busy high for 2 cycles.
- RD_LAT=1 back-to-back: read_enable held high across two reads of addr 1 (=0x11) and addr 2 (=0x22). Expect ready pulses 2 cycles apart, never consecutive; data 0x11 then 0x22.
- Same-edge collision: read_enable with raddr=7 and write_enable with waddr=7, wdata=0xA5A5A5A5 at the same edge. Expect rdata=0xA5A5A5A5.
- Later write during BUSY: write 0x1234 to the pending address. Expect the old value returned; a subsequent read returns 0x1234.
- Out of range: DEPTH=1024, write addr 1024 then read addr 1024. Expect rdata=0, mem unchanged; with CANDY_MEM_RESP_ERR_EN, addr_err pulses twice.
- Reset mid-read: rst asserted one cycle after acceptance. Expect no rdata_ready, rdata=0, busy=0 next cycle, and the next read behaves normally.

Source files
------------

// File: rtl/candy_mem_resp_pkg.sv
// Shared definitions for the candy memory responder: SRAM widths, FSM encoding, default read latency.
package candy_mem_resp_pkg;

  localparam int SRAM_ADDR_W    = 16;
  localparam int SRAM_DATA_W    = 32;
  localparam int RD_LAT_DEFAULT = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Counter preload on acceptance; BUSY hands over to RESP when the count reaches 1.
  function automatic logic [3:0] lat_preload(input int rd_lat);
    return 4'(rd_lat - 1);
  endfunction

endpackage

// File: rtl/candy_mem_array.sv
// Word-addressed storage with one synchronous write port and one snapshot read port (write-first).
module candy_mem_array
  import candy_mem_resp_pkg::*;
#(
  parameter int ADDR_W = SRAM_ADDR_W,
  parameter int DATA_W = SRAM_DATA_W,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rd_word,
  output logic              rd_oor,
  output logic              wr_oor
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CMP_W = ADDR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  ridx;
  logic [IDX_W-1:0]  widx;
  logic              wr_hit;

  // Full-width unsigned range checks; the index is only used once the address is known in range.
  assign rd_oor = (CMP_W'(raddr) >= CMP_W'(DEPTH));
  assign wr_oor = we && (CMP_W'(waddr) >= CMP_W'(DEPTH));
  assign ridx   = raddr[IDX_W-1:0];
  assign widx   = waddr[IDX_W-1:0];
  assign wr_hit = we && !wr_oor && (waddr == raddr);

  always_ff @(posedge clk) begin
    if (we && !wr_oor) begin
      mem[widx] <= wdata;
    end
    if (rd_en) begin
      if (rd_oor) begin
        rd_word <= '0;
      end else if (wr_hit) begin
        rd_word <= wdata;
      end else begin
        rd_word <= mem[ridx];
      end
    end
  end

endmodule

// File: rtl/candy_mem_resp.sv
// Memory responder: read handshake FSM with RD_LAT latency over candy_mem_array.
// Optional addr_err output enabled by defining CANDY_MEM_RESP_ERR_EN.
module candy_mem_resp
  import candy_mem_resp_pkg::*;
#(
  parameter int ADDR_W = SRAM_ADDR_W,
  parameter int DATA_W = SRAM_DATA_W,
  parameter int DEPTH  = 1024,
  parameter int RD_LAT = RD_LAT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read_enable,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_ready,
  input  logic              write_enable,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy
`ifdef CANDY_MEM_RESP_ERR_EN
  ,
  output logic              addr_err
`endif
);

  localparam logic [3:0] CNT_INIT = lat_preload(RD_LAT);

  state_t            state;
  logic [3:0]        cnt;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] held;
  logic              accept;
  logic              to_resp;
  logic              rd_oor;
  logic              wr_oor;

  assign accept  = (state == ST_IDLE) && read_enable;
  assign to_resp = (accept && (RD_LAT == 1)) || ((state == ST_BUSY) && (cnt == 4'd1));

  candy_mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk     (clk),
    .rd_en   (accept),
    .raddr   (raddr),
    .we      (write_enable),
    .waddr   (waddr),
    .wdata   (wdata),
    .rd_word (held),
    .rd_oor  (rd_oor),
    .wr_oor  (wr_oor)
  );

  // The snapshot register is presented during RESP and copied to rdata_q as RESP ends,
  // so rdata stays put until the next response even though later reads reload the snapshot.
  assign rdata = (state == ST_RESP) ? held : rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= 4'd0;
      rdata_ready <= 1'b0;
      busy        <= 1'b0;
      rdata_q     <= '0;
    end else begin
      rdata_ready <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (read_enable) begin
            busy <= 1'b1;
            if (RD_LAT == 1) begin
              state       <= ST_RESP;
              rdata_ready <= 1'b1;
            end else begin
              state <= ST_BUSY;
              cnt   <= CNT_INIT;
            end
          end
        end
        ST_BUSY: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state       <= ST_RESP;
            rdata_ready <= 1'b1;
          end
        end
        ST_RESP: begin
          state   <= ST_IDLE;
          busy    <= 1'b0;
          rdata_q <= held;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef CANDY_MEM_RESP_ERR_EN
  logic pend_oor;
  logic err_q;

  // Read and write error sources can land in the same cycle; OR-ing them gives one pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_oor <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (accept) begin
        pend_oor <= rd_oor;
      end
      err_q <= wr_oor || (to_resp && (accept ? rd_oor : pend_oor));
    end
  end

  assign addr_err = err_q;
`else
  logic unused_oor;
  assign unused_oor = rd_oor ^ wr_oor ^ to_resp;
`endif

endmodule

// File: tb/tb_candy_mem_resp.sv
// Self-checking bench for candy_mem_resp: RD_LAT=2 and RD_LAT=1 instances sharing the write port.
module tb_candy_mem_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [15:0] waddr;
  logic [31:0] wdata;
  logic        re1, re2;
  logic [15:0] ra1, ra2;
  logic [31:0] rd1, rd2;
  logic        rdy1, rdy2, busy1, busy2;
`ifdef CANDY_MEM_RESP_ERR_EN
  logic        err1, err2;
`endif

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] model [1024];

  always #5 clk = ~clk;

  candy_mem_resp #(.RD_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .read_enable(re2), .raddr(ra2), .rdata(rd2), .rdata_ready(rdy2),
    .write_enable(we), .waddr(waddr), .wdata(wdata), .busy(busy2)
`ifdef CANDY_MEM_RESP_ERR_EN
    , .addr_err(err2)
`endif
  );

  candy_mem_resp #(.RD_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .read_enable(re1), .raddr(ra1), .rdata(rd1), .rdata_ready(rdy1),
    .write_enable(we), .waddr(waddr), .wdata(wdata), .busy(busy1)
`ifdef CANDY_MEM_RESP_ERR_EN
    , .addr_err(err1)
`endif
  );

  function automatic logic [31:0] ref_read(input logic [15:0] a);
    return (a < 16'd1024) ? model[a[9:0]] : 32'h0;
  endfunction

  function automatic logic [31:0] f_rdata(input int sel);
    return (sel == 1) ? rd1 : rd2;
  endfunction
  function automatic logic f_rdy(input int sel);
    return (sel == 1) ? rdy1 : rdy2;
  endfunction
  function automatic logic f_busy(input int sel);
    return (sel == 1) ? busy1 : busy2;
  endfunction
`ifdef CANDY_MEM_RESP_ERR_EN
  function automatic logic f_err(input int sel);
    return (sel == 1) ? err1 : err2;
  endfunction
`endif

  task automatic set_read(input int sel, input logic en, input logic [15:0] a);
    if (sel == 1) begin re1 = en; ra1 = a; end
    else begin re2 = en; ra2 = a; end
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    @(negedge clk);
    we = 1'b1; waddr = a; wdata = d;
    @(posedge clk);
    if (a < 16'd1024) model[a[9:0]] = d;
    #1;
    we = 1'b0;
`ifdef CANDY_MEM_RESP_ERR_EN
    vectors++;
    if (err1 !== (a >= 16'd1024) || err2 !== (a >= 16'd1024)) begin
      miscompares++;
      $display("FAIL wr_addr_err a=%0d got %b/%b required %b", a, err1, err2, (a >= 16'd1024));
    end
`endif
  endtask

  // wmode: 0 no write, 1 write same address on the acceptance edge, 2 write it one edge later.
  task automatic read_txn(input int sel, input int lat, input logic [15:0] a,
                          input int wmode, input logic [31:0] wd, output logic [31:0] got);
    logic [31:0] exp;
    int j;
    bit seen;
    @(negedge clk);
    set_read(sel, 1'b1, a);
    if (wmode == 1) begin we = 1'b1; waddr = a; wdata = wd; end
    @(posedge clk);
    if (wmode == 1 && a < 16'd1024) model[a[9:0]] = wd;
    exp = ref_read(a);
    j = 0;
    seen = 1'b0;
    while (!seen && j < 20) begin
      #1;
      j++;
      we = 1'b0;
      vectors++;
      if (f_busy(sel) !== 1'b1) begin
        miscompares++;
        $display("FAIL busy_in_flight sel=%0d cyc=%0d got %b required 1", sel, j, f_busy(sel));
      end
      if (f_rdy(sel) === 1'b1) begin
        seen = 1'b1;
        set_read(sel, 1'b0, a);
        vectors++;
        if (j != lat) begin
          miscompares++;
          $display("FAIL latency sel=%0d a=%0d got %0d required %0d", sel, a, j, lat);
        end
        vectors++;
        if (f_rdata(sel) !== exp) begin
          miscompares++;
          $display("FAIL rdata sel=%0d a=%0d got %h required %h", sel, a, f_rdata(sel), exp);
        end
`ifdef CANDY_MEM_RESP_ERR_EN
        vectors++;
        if (f_err(sel) !== (a >= 16'd1024)) begin
          miscompares++;
          $display("FAIL rd_addr_err sel=%0d a=%0d got %b required %b", sel, a, f_err(sel), (a >= 16'd1024));
        end
`endif
      end else begin
        if (wmode == 2 && j == 1) begin we = 1'b1; waddr = a; wdata = wd; end
        @(posedge clk);
        if (we && waddr < 16'd1024) model[waddr[9:0]] = wdata;
      end
    end
    we = 1'b0;
    if (!seen) begin
      miscompares++;
      $display("FAIL ready_timeout sel=%0d a=%0d got none required pulse", sel, a);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (f_rdy(sel) !== 1'b0 || f_busy(sel) !== 1'b0 || f_rdata(sel) !== exp) begin
      miscompares++;
      $display("FAIL after_resp sel=%0d rdy=%b busy=%b rdata=%h required 0 0 %h",
               sel, f_rdy(sel), f_busy(sel), f_rdata(sel), exp);
    end
    got = f_rdata(sel);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (rdy1 !== 1'b0 || rdy2 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ready got %b/%b required 0/0", rdy1, rdy2);
    end
    vectors++;
    if (busy1 !== 1'b0 || busy2 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_busy got %b/%b required 0/0", busy1, busy2);
    end
    vectors++;
    if (rd1 !== 32'h0 || rd2 !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_rdata got %h/%h required 0/0", rd1, rd2);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [31:0] g;
    wr(16'd5, 32'hDEADBEEF);
    read_txn(2, 2, 16'd5, 0, 32'h0, g);
    read_txn(1, 1, 16'd5, 0, 32'h0, g);
  endtask

  task automatic test_back_to_back();
    int cyc_q[$];
    logic [31:0] dat_q[$];
    logic prev;
    wr(16'd1, 32'h11);
    wr(16'd2, 32'h22);
    @(negedge clk);
    re1 = 1'b1; ra1 = 16'd1;
    prev = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (rdy1 === 1'b1) begin
        vectors++;
        if (prev) begin
          miscompares++;
          $display("FAIL ready_consecutive cyc=%0d got 1 required 0", c);
        end
        cyc_q.push_back(c);
        dat_q.push_back(rd1);
        if (cyc_q.size() == 1) ra1 = 16'd2;
        else re1 = 1'b0;
      end
      prev = rdy1;
    end
    re1 = 1'b0;
    vectors++;
    if (cyc_q.size() != 2) begin
      miscompares++;
      $display("FAIL b2b_pulses got %0d required 2", cyc_q.size());
    end else begin
      vectors++;
      if (cyc_q[1] - cyc_q[0] != 2 || cyc_q[0] != 0) begin
        miscompares++;
        $display("FAIL b2b_spacing got %0d,%0d required 0,2", cyc_q[0], cyc_q[1]);
      end
      vectors++;
      if (dat_q[0] !== 32'h11 || dat_q[1] !== 32'h22) begin
        miscompares++;
        $display("FAIL b2b_data got %h,%h required 00000011,00000022", dat_q[0], dat_q[1]);
      end
    end
  endtask

  task automatic test_collision();
    logic [31:0] g;
    wr(16'd7, 32'h01010101);
    read_txn(2, 2, 16'd7, 1, 32'hA5A5A5A5, g);
    read_txn(1, 1, 16'd7, 1, 32'h5A5A5A5A, g);
  endtask

  task automatic test_late_write();
    logic [31:0] g;
    wr(16'd9, 32'h00000999);
    read_txn(2, 2, 16'd9, 2, 32'h00001234, g);
    vectors++;
    if (g !== 32'h00000999) begin
      miscompares++;
      $display("FAIL late_write_old got %h required 00000999", g);
    end
    read_txn(2, 2, 16'd9, 0, 32'h0, g);
    vectors++;
    if (g !== 32'h00001234) begin
      miscompares++;
      $display("FAIL late_write_new got %h required 00001234", g);
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] g;
    wr(16'd0, 32'hCAFEF00D);
    wr(16'd1024, 32'hBAD0BAD0);
    read_txn(2, 2, 16'd1024, 0, 32'h0, g);
    read_txn(1, 1, 16'hFFFF, 0, 32'h0, g);
    read_txn(2, 2, 16'd0, 0, 32'h0, g);
    vectors++;
    if (g !== 32'hCAFEF00D) begin
      miscompares++;
      $display("FAIL oor_no_alias got %h required cafef00d", g);
    end
  endtask

  task automatic test_reset_mid_read();
    logic [31:0] g;
    @(negedge clk);
    re2 = 1'b1; ra2 = 16'd5;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1; re2 = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if (rdy2 !== 1'b0 || busy2 !== 1'b0 || rd2 !== 32'h0) begin
      miscompares++;
      $display("FAIL mid_reset got rdy=%b busy=%b rdata=%h required 0 0 0", rdy2, busy2, rd2);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      vectors++;
      if (rdy2 !== 1'b0) begin
        miscompares++;
        $display("FAIL aborted_ready cyc=%0d got 1 required 0", c);
      end
    end
    read_txn(2, 2, 16'd5, 0, 32'h0, g);
  endtask

  task automatic test_random();
    logic [31:0] g;
    logic [15:0] a;
    int op;
    for (int i = 0; i < 32; i++) wr(16'(100 + i), $urandom);
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 4) == 0) a = 16'($urandom_range(1024, 1100));
      else a = 16'($urandom_range(100, 131));
      op = $urandom_range(0, 2);
      case (op)
        0: wr(a, $urandom);
        1: read_txn(2, 2, a, $urandom_range(0, 2), $urandom, g);
        default: read_txn(1, 1, a, $urandom_range(0, 1), $urandom, g);
      endcase
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
    re1 = 1'b0; re2 = 1'b0; ra1 = '0; ra2 = '0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_collision();
    test_late_write();
    test_out_of_range();
    test_reset_mid_read();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
